div_multicycle: RTL

Parametrised iterative integer divider producing quotient (Lo) and remainder (Hi) for the multi-cycle datapath's DIV/DIVU instructions. It generalises the fixed 32-bit signed divider in three ways: configurable operand width, per-operation signed/unsigned mode, and an explicit busy/done handshake. It is a radix-2 restoring divider with one quotient bit per clock, driven by the control FSM.

---
 rtl/div_multicycle.sv | 114 +++++++++++
 1 files changed

// File: rtl/div_multicycle.sv
// div_multicycle: radix-2 restoring divider, one quotient bit per clock, signed/unsigned, busy/done handshake
module div_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
    logic             divzero_q, divzero_d, dzp_q, dzp_d;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] mag_a, mag_b;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        busy_d    = busy_q;
        divzero_d = divzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dzp_d     = 1'b0;
        done_d    = dzp_q;
        mag_a     = (is_signed && dividendo[WIDTH-1]) ? -dividendo : dividendo;
        mag_b     = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        case (state_q)
            IDLE: if (start) begin
                qneg_d = is_signed & (dividendo[WIDTH-1] ^ divisor[WIDTH-1]);
                rneg_d = is_signed & dividendo[WIDTH-1];
                quo_d  = mag_a;
                dvs_d  = mag_b;
                rem_d  = '0;
                if (divisor == '0) begin
                    divzero_d = 1'b1;
                    dzp_d     = 1'b1;
                end else begin
                    divzero_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(WIDTH);
                    state_d   = RUN;
                end
            end
            RUN: begin
                // a borrow out of the trial subtraction means restore and shift in 0
                rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            dzp_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            dzp_q     <= dzp_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
endmodule
